// File: rtl/gray_counter_if.sv
// rtl/gray_counter_if.sv - control and count signals of the up/down Gray counter
interface gray_counter_if #(
  parameter int N = 8
);
  logic         en;
  logic         up_dn;
  logic         load;
  logic [N-1:0] load_val;
  logic [N-1:0] binary;
  logic [N-1:0] gray;
  logic         tc;
  logic         wrap;

  modport master (
    output en, up_dn, load, load_val,
    input  binary, gray, tc, wrap
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output binary, gray, tc, wrap
  );
endinterface

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - loadable up/down binary counter with registered Gray copy
// GRAY_CNT_SAT_EN: saturate at the terminal count instead of wrapping (wrap tied low).
module gray_counter #(
  parameter int           N    = 8,
  parameter logic [N-1:0] INIT = '0
) (
  input  logic           clk,
  input  logic           rst,
  gray_counter_if.slave  cnt
);

  localparam logic [N-1:0] ONE       = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] INIT_GRAY = INIT ^ (INIT >> 1);

  logic [N-1:0] binary_q, binary_d;
  logic [N-1:0] gray_q, gray_d;
  logic         tc;

  always_comb begin
    tc = cnt.up_dn ? (&binary_q) : ~(|binary_q);
  end

  always_comb begin
    binary_d = binary_q;
    if (cnt.load) begin
      binary_d = cnt.load_val;
    end else if (cnt.en) begin
`ifdef GRAY_CNT_SAT_EN
      if (!tc) begin
        binary_d = cnt.up_dn ? (binary_q + ONE) : (binary_q - ONE);
      end
`else
      binary_d = cnt.up_dn ? (binary_q + ONE) : (binary_q - ONE);
`endif
    end
    // Encode from the next value so binary and gray land on the same edge.
    gray_d = binary_d ^ (binary_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      binary_q <= INIT;
      gray_q   <= INIT_GRAY;
    end else begin
      binary_q <= binary_d;
      gray_q   <= gray_d;
    end
  end

`ifdef GRAY_CNT_SAT_EN
  assign cnt.wrap = 1'b0;
`else
  logic wrap_q, wrap_d;

  always_comb begin
    wrap_d = cnt.en & ~cnt.load & tc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign cnt.wrap = wrap_q;
`endif

  assign cnt.binary = binary_q;
  assign cnt.gray   = gray_q;
  assign cnt.tc     = tc;

endmodule

// File: tb/tb_gray_counter.sv
// tb/tb_gray_counter.sv - scoreboard bench for gray_counter (N=4, INIT=0 and INIT=1010)
module tb_gray_counter;

  typedef struct {
    int         which;
    logic [3:0] bin;
    logic [3:0] gry;
    logic       wrap;
    logic       tc;
    logic       step_chk;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  logic [3:0] gtab [16];
  logic [3:0] prev_gray [2];

  always #5 clk = ~clk;

  gray_counter_if #(.N(4)) if_a ();
  gray_counter_if #(.N(4)) if_b ();

  gray_counter #(.N(4), .INIT(4'b0000)) dut_a (.clk(clk), .rst(rst_a), .cnt(if_a));
  gray_counter #(.N(4), .INIT(4'b1010)) dut_b (.clk(clk), .rst(rst_b), .cnt(if_b));

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // One stimulus cycle on the selected DUT; the other one holds.
  task automatic step(input int which, input logic r, input logic ld, input logic e,
                      input logic ud, input logic [3:0] lv, input logic [3:0] eb,
                      input logic [3:0] eg, input logic ew, input logic et,
                      input logic sc);
    exp_t x;
    @(negedge clk);
    rst_a = (which == 0) ? r : 1'b0;
    rst_b = (which == 1) ? r : 1'b0;
    if_a.load = (which == 0) ? ld : 1'b0;
    if_a.en   = (which == 0) ? e  : 1'b0;
    if_b.load = (which == 1) ? ld : 1'b0;
    if_b.en   = (which == 1) ? e  : 1'b0;
    if (which == 0) begin
      if_a.up_dn = ud; if_a.load_val = lv;
    end else begin
      if_b.up_dn = ud; if_b.load_val = lv;
    end
    x.which = which; x.bin = eb; x.gry = eg; x.wrap = ew; x.tc = et; x.step_chk = sc;
    sb.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t x;
      logic [3:0] b, g;
      logic w, t;
      x = sb.pop_front();
      b = (x.which == 0) ? if_a.binary : if_b.binary;
      g = (x.which == 0) ? if_a.gray   : if_b.gray;
      w = (x.which == 0) ? if_a.wrap   : if_b.wrap;
      t = (x.which == 0) ? if_a.tc     : if_b.tc;
      check("binary", b, x.bin);
      check("gray", g, x.gry);
      check("wrap", {3'b000, w}, {3'b000, x.wrap});
      check("tc", {3'b000, t}, {3'b000, x.tc});
      if (x.step_chk) begin
        check("gray_one_bit", 4'($countones(g ^ prev_gray[x.which])), 4'd1);
      end
      prev_gray[x.which] = g;
    end
  end

  initial begin
    gtab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    prev_gray[0] = 4'b0000;
    prev_gray[1] = 4'b0000;
    if_a.en = 1'b0; if_a.up_dn = 1'b0; if_a.load = 1'b0; if_a.load_val = 4'b0000;
    if_b.en = 1'b0; if_b.up_dn = 1'b0; if_b.load = 1'b0; if_b.load_val = 4'b0000;

    // Reset and hold.
    step(0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 4'd0, 4'b1010, 4'b1111, 0, 0, 0);
    step(0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 1, 0);

    // Full up-count through the wrap.
    for (int k = 1; k <= 16; k++) begin
      logic [3:0] bv;
      bv = 4'(k);
      step(0, 0, 0, 1, 1, 4'd0, bv, gtab[bv], k == 16, bv == 4'd15, 1);
    end

    // Down wrap from a loaded 0001.
    step(0, 0, 1, 0, 0, 4'd1, 4'd1, 4'b0001, 0, 0, 0);
    step(0, 0, 0, 1, 0, 4'd0, 4'd0, 4'b0000, 0, 1, 1);
    step(0, 0, 0, 1, 0, 4'd0, 4'd15, 4'b1000, 1, 0, 1);
    step(0, 0, 0, 0, 0, 4'd0, 4'd15, 4'b1000, 0, 0, 0);

    // Load priority over en, load at terminal count, reset over load.
    step(0, 0, 1, 0, 1, 4'd5, 4'd5, 4'b0111, 0, 0, 0);
    step(0, 0, 1, 1, 1, 4'd15, 4'd15, 4'b1000, 0, 1, 0);
    step(0, 0, 1, 1, 1, 4'd0, 4'd0, 4'b0000, 0, 0, 0);
    step(0, 0, 1, 0, 1, 4'd15, 4'd15, 4'b1000, 0, 1, 0);
    step(0, 1, 1, 1, 1, 4'd15, 4'd0, 4'b0000, 0, 0, 0);

    // Direction change between wraps.
    step(0, 0, 0, 0, 0, 4'd0, 4'd0, 4'b0000, 0, 1, 0);
    step(0, 0, 0, 1, 0, 4'd0, 4'd15, 4'b1000, 1, 0, 1);
    step(0, 0, 0, 1, 1, 4'd0, 4'd0, 4'b0000, 1, 0, 1);

    // INIT = 1010: count up, then reset mid-count with en and load high.
    step(1, 0, 0, 1, 1, 4'd0, 4'b1011, 4'b1110, 0, 0, 1);
    step(1, 0, 0, 1, 1, 4'd0, 4'b1100, 4'b1010, 0, 0, 1);
    step(1, 1, 1, 1, 1, 4'd3, 4'b1010, 4'b1111, 0, 0, 0);

    @(negedge clk);
    if_a.en = 1'b0; if_a.load = 1'b0; if_b.en = 1'b0; if_b.load = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Free-running/loadable up/down binary counter with a registered Gray-coded copy of its count.
- Sits directly upstream of the binary-to-Gray conversion stage and absorbs it: produces the binary count and its Gray encoding in the same cycle, both registered.
- Used as the source of Gray-coded pointers and position codes.
- Gray output changes by exactly one bit per count step; no combinational glitch path to `gray`.

Parameters:
- N, 8: counter and code width in bits; N >= 2.
- INIT, 0: binary reset value (N bits); `gray` resets to the Gray encoding of INIT.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable; one step per clk while high.
- up_dn  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load of load_val.
- load_val  input  N  binary value to load.
- binary  output  N  registered binary count.
- gray  output  N  registered Gray code of binary: gray = binary ^ (binary >> 1), MSB passes through.
- tc  output  1  terminal count (combinational from registered binary and up_dn).
- wrap  output  1  registered one-cycle pulse, count wrapped on previous edge.

Behaviour:
- Reset (rst = 1 at posedge): binary = INIT, gray = INIT ^ (INIT >> 1), wrap = 0. Overrides load and en.
- Priority per edge: rst > load > en > hold.
- Next-state value bnext:
  - load: bnext = load_val.
  - en & up_dn: bnext = binary + 1, modulo 2^N.
  - en & !up_dn: bnext = binary - 1, modulo 2^N.
  - otherwise: bnext = binary.
- binary <= bnext and gray <= bnext ^ (bnext >> 1) on the same edge. Both outputs always mutually consistent, zero-cycle skew, latency 1 clk from en/load to output.
- Gray encoding is computed from bnext, never from registered binary. There must be no extra pipeline cycle.
- tc:
  - up_dn = 1: tc = 1 when binary == 2^N-1.
  - up_dn = 0: tc = 1 when binary == 0.
  - tc is independent of en.
- wrap: set to 1 for exactly one cycle after an edge where en = 1, load = 0, rst = 0 and tc = 1, i.e. the count went max->0 or 0->max. Otherwise 0.
- load with any value, including max or 0, never asserts wrap.
- load and en high together: load wins, no count step, wrap = 0.
- up_dn may change every cycle; direction is sampled only on edges where en = 1.
- rst asserted mid-count: next edge returns to INIT regardless of other inputs; wrap cleared the same edge.
- No internal state beyond the binary register, gray register and wrap flop.

Optional Feature:
- Macro GRAY_CNT_SAT_EN.
- Defined: counter saturates instead of wrapping.
  - With en = 1 and tc = 1, binary and gray hold, and wrap is permanently 0 (tied low).
  - load and rst unaffected.
- Undefined: modulo-2^N wrap-around with the wrap pulse as above.

Test Plan (N = 4, INIT = 0 unless stated):
- Reset then hold: rst for 2 clk, en = 0 -> binary = 0000, gray = 0000, wrap = 0, tc = 1 with up_dn = 0.
- Full up-count: en = 1, up_dn = 1, 16 clk.
  - gray sequence must be 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000.
  - Exactly one gray bit changes per step.
  - tc high at binary 1111; wrap = 1 only the cycle binary returns to 0000.
- Down wrap: load_val = 0001, load 1 clk, then en = 1, up_dn = 0 for 2 clk.
  - binary 0001 -> 0000 -> 1111, gray 0001 -> 0000 -> 1000.
  - wrap pulses once after the 0000 -> 1111 edge.
- Load priority: binary = 0101, en = 1, load = 1, load_val = 1111 -> next binary = 1111, gray = 1000, wrap = 0; load has no effect when rst is also high (binary = 0000).
- Reset mid-count with INIT = 1010: count up to 1100, assert rst with en = 1 and load = 1 -> binary = 1010, gray = 1111, wrap = 0.
- GRAY_CNT_SAT_EN defined: up-count from 1110 for 3 clk -> binary = 1111, gray = 1000, held; wrap never asserts. Down-count from 0001 holds at 0000.
